lbc_pool_flatten: RTL and testbench
===================================

# lbc_pool_flatten

Upstream feeder for the fully connected layer. Accepts the LBC convolution output feature map as a row-major pixel stream with a valid/ready handshake. Applies 2x2 stride-2 max pooling and writes the pooled map into a flatten buffer. Once the buffer is complete it is presented as one parallel vector for the FC stage, held stable until acknowledged.

## Interface
- IN_W, 16, feature-map width in pixels; even, at least 2.
- IN_H, 16, feature-map height in pixels; even, at least 2.
- OUT_N, (IN_W/2)*(IN_H/2) = 64, flatten length; equals IP_LAYER*NUM_INP of the FC layer.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- in_valid  in  1  in_data carries a pixel this cycle.
- in_ready  out  1  block accepts a pixel this cycle.
- in_data  in  16  signed pixel, two's complement.
- vec_out  out  16 x OUT_N  signed unpacked array [0:OUT_N-1], flatten buffer contents.
- vec_valid  out  1  vec_out holds a complete pooled frame; directly usable as the FC layer's active-low rst/run.
- vec_ack  in  1  consumer releases the vector.

## Operation
- States:
  - LOAD: in_ready=1.
  - FULL: in_ready=0, vec_valid=1.
- Counters:
  - col 0..IN_W-1 and row 0..IN_H-1 advance only on handshake (in_valid & in_ready).
  - col wraps to 0 and row increments at col=IN_W-1.
- Row buffer: IN_W/2 signed 16-bit partial maxima, indexed p=col/2.
  - Even row, even col: part[p] <= in_data.
  - Otherwise: part[p] <= max(part[p], in_data), signed compare.
- Flatten write, on odd row and odd col:
  - m = max(part[p], in_data).
  - buf[(row/2)*(IN_W/2)+p] <= m.
- Handshake at row=IN_H-1, col=IN_W-1: final buffer write, state -> FULL, counters -> 0.
- FULL, vec_ack=1: state -> LOAD, vec_valid -> 0. Buffer is not cleared; it is overwritten by the next frame. vec_ack is ignored in LOAD.
- in_valid during FULL: no handshake, no counter or buffer change.
- Pixel values are never widened or saturated. Max pooling is exact.

## Timing
- Reset values:
  - state LOAD, in_ready=1, vec_valid=0.
  - col=row=0.
  - All part[] and buf[] entries are 0, so vec_out is all 0.
- Reset mid-frame discards all partial data. The next accepted pixel is treated as (0,0).
- Reset overrides vec_ack and in_valid in the same cycle.
- Throughput: one pixel per cycle in LOAD.
- Latency: the last pixel is accepted at edge k. vec_valid=1 and in_ready=0 are visible after edge k.
- vec_ack is sampled at edge m with vec_valid=1. in_ready=1 and vec_valid=0 are visible after edge m.
  - The minimum FULL duration is 1 cycle.
  - The first pixel of the next frame can be accepted in the cycle after m.
- in_ready is a function of state only, with no combinational path from in_valid or vec_ack.
- vec_out is stable for the whole FULL interval.

## Configuration
- POOL_RELU_EN:
  - Defined: the value written to buf is m clamped to 0 when m[15]=1, giving ReLU after pooling.
  - Undefined: m is stored unchanged.
- Row-buffer partial maxima are never clamped.

## Structure
- Shared package lbc_pkg holds:
  - ACT_W=16.
  - typedef act_t (logic signed [ACT_W-1:0]).
  - typedef enum lbc_pf_state_t {LOAD, FULL}.
  - Default map dimensions (MAP_W=16, MAP_H=16).
- Sub-module pool_row_buffer:
  - Parameter DEPTH=IN_W/2.
  - Holds part[]; inputs p, we, first (even row and even col), in_data.
  - Outputs the combinational m = max(part[p], in_data).
- The top holds the counters, state machine and flatten buffer.

## Test plan
- Ramp: feed in_data = row*16+col for all 256 pixels with in_valid held high.
  - Expect vec_out[i] = (2*(i/8)+1)*16 + 2*(i%8)+1; for example vec_out[0]=17 and vec_out[63]=255.
  - Expect vec_valid high the cycle after the 256th accept.
- Single peak: all zeros except 100 at (row 3, col 5).
  - Expect vec_out[10]=100 and all other entries 0.
- Negative frame: all pixels -5.
  - With POOL_RELU_EN: all 64 outputs 0.
  - Without it: all 64 outputs -5.
- Backpressure: hold in_valid=1 with new data during a 20-cycle FULL.
  - Expect in_ready=0 and vec_out unchanged.
  - Assert vec_ack; the next frame starts one cycle later, and its ramp result is correct.
- Bubbles: random in_valid deassertion of about 50% on the ramp frame.
  - Expect results identical to the ramp test and vec_valid only after the 256th accept.
- Reset mid-frame: pull rst low for 1 cycle after 100 accepts.
  - Expect vec_valid=0, in_ready=1 and all vec_out 0.
  - A following full ramp frame gives correct results.

Source files
------------

// File: rtl/lbc_pkg.sv
// lbc_pkg: shared types and defaults for the LBC feature-map pipeline.
// Holds the activation type, the pool/flatten state encoding and default
// map dimensions used by lbc_pool_flatten and its row buffer.
package lbc_pkg;

  localparam int ACT_W = 16;
  localparam int MAP_W = 16;
  localparam int MAP_H = 16;

  typedef logic signed [ACT_W-1:0] act_t;

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } lbc_pf_state_t;

  // Exact signed maximum of two activations.
  function automatic act_t act_max(input act_t a, input act_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lbc_pool_flatten_pool_row_buffer.sv
// pool_row_buffer: one row of 2x2 max-pool partial maxima.
// Entry p tracks the running maximum of the 2x2 window covering columns
// 2p and 2p+1 of the current row pair. The combinational output m is the
// maximum of the stored partial and the incoming pixel, which on the
// bottom-right pixel of a window is the finished pooled value.
module pool_row_buffer
  import lbc_pkg::*;
#(
  parameter  int DEPTH = MAP_W / 2,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PW-1:0]           p,
  input  logic                    we,
  input  logic                    first,
  input  logic signed [ACT_W-1:0] in_data,
  output logic signed [ACT_W-1:0] m
);

  act_t part_q [DEPTH];

  assign m = act_max(part_q[p], in_data);

  // Start a window on its top-left pixel, otherwise fold the pixel into the partial maximum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) part_q[i] <= '0;
    end else if (we) begin
      part_q[p] <= first ? in_data : m;
    end
  end

endmodule

// File: rtl/lbc_pool_flatten.sv
// lbc_pool_flatten: 2x2 stride-2 max pooling of a row-major pixel stream
// into a flatten buffer presented as one parallel vector to the FC stage.
// The vector is held stable while vec_valid is high, until vec_ack.
// Optional feature macro: POOL_RELU_EN -- when defined, each pooled value
// is clamped to 0 if negative before being stored (ReLU after pooling).
module lbc_pool_flatten
  import lbc_pkg::*;
#(
  parameter int IN_W  = MAP_W,
  parameter int IN_H  = MAP_H,
  parameter int OUT_N = (IN_W / 2) * (IN_H / 2)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ACT_W-1:0] in_data,
  output logic signed [ACT_W-1:0] vec_out [0:OUT_N-1],
  output logic                    vec_valid,
  input  logic                    vec_ack
);

  localparam int HALF_W = IN_W / 2;
  localparam int CW     = $clog2(IN_W);
  localparam int RW     = $clog2(IN_H);
  localparam int PW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int IW     = (OUT_N > 1) ? $clog2(OUT_N) : 1;

  lbc_pf_state_t   state_q;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic            in_ready_q;
  logic            vec_valid_q;

  logic            hs;
  logic            col_last;
  logic            row_last;
  logic [PW-1:0]   p;
  logic            first;
  logic            pool_wr;
  logic [IW-1:0]   idx;
  act_t            m;
  act_t            buf_q [0:OUT_N-1];

  // Stored value of a finished pooling window.
  function automatic act_t store_val(input act_t v);
`ifdef POOL_RELU_EN
    return v[ACT_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  assign hs       = in_valid & in_ready_q;
  assign col_last = (col_q == CW'(IN_W - 1));
  assign row_last = (row_q == RW'(IN_H - 1));
  assign p        = PW'(col_q >> 1);
  assign first    = ~row_q[0] & ~col_q[0];
  assign pool_wr  = hs & row_q[0] & col_q[0];
  assign idx      = IW'((int'(row_q) / 2) * HALF_W + int'(p));

  assign in_ready  = in_ready_q;
  assign vec_valid = vec_valid_q;
  assign vec_out   = buf_q;

  pool_row_buffer #(
    .DEPTH (HALF_W)
  ) u_row_buf (
    .clk     (clk),
    .rst     (rst),
    .p       (p),
    .we      (hs),
    .first   (first),
    .in_data (in_data),
    .m       (m)
  );

  // Raster-scan position advances only on an accepted pixel; wraps to (0,0) after the last one.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (hs) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Frame state machine with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LOAD;
      col_q       <= '0;
      row_q       <= '0;
      in_ready_q  <= 1'b1;
      vec_valid_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      case (state_q)
        LOAD: begin
          if (hs && col_last && row_last) begin
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
            vec_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (vec_ack) begin
            state_q     <= LOAD;
            in_ready_q  <= 1'b1;
            vec_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= LOAD;
          in_ready_q  <= 1'b1;
          vec_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Flatten buffer: a pooled value lands when the bottom-right pixel of its window is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < OUT_N; i++) buf_q[i] <= '0;
    end else if (pool_wr) begin
      buf_q[idx] <= store_val(m);
    end
  end

endmodule

// File: tb/tb_lbc_pool_flatten.sv
// Testbench for lbc_pool_flatten: frame-level stimulus with a scoreboard
// queue of expected pooled vectors and an independent output monitor.
module tb_lbc_pool_flatten;

  localparam int W = 16;
  localparam int H = 16;
  localparam int N = 64;

  localparam int K_RAMP = 0;
  localparam int K_PEAK = 1;
  localparam int K_NEG  = 2;
  localparam int K_RAND = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic signed [15:0] vec_out [0:N-1];
  logic               vec_valid;
  logic               vec_ack;

  int checks = 0;
  int errors = 0;

  logic signed [15:0] exp_q [$];
  logic signed [15:0] snap  [N];
  bit                 prev_vv = 1'b0;
  bit                 mon_en  = 1'b0;

  lbc_pool_flatten #(
    .IN_W  (W),
    .IN_H  (H),
    .OUT_N (N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .vec_ack   (vec_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // Reference: each output is the exact maximum of its 2x2 window, optionally clamped at 0.
  task automatic push_expected(input int img [H][W]);
    for (int br = 0; br < H / 2; br++) begin
      for (int bc = 0; bc < W / 2; bc++) begin
        int mx;
        mx = img[2*br][2*bc];
        if (img[2*br][2*bc+1]   > mx) mx = img[2*br][2*bc+1];
        if (img[2*br+1][2*bc]   > mx) mx = img[2*br+1][2*bc];
        if (img[2*br+1][2*bc+1] > mx) mx = img[2*br+1][2*bc+1];
`ifdef POOL_RELU_EN
        if (mx < 0) mx = 0;
`endif
        exp_q.push_back(16'(mx));
      end
    end
  endtask

  // Monitor: compare a new vector against the scoreboard, then require it stable while held.
  always @(negedge clk) begin
    if (mon_en && rst) begin
      checks++;
      if (in_ready !== !vec_valid) begin
        errors++;
        $display("FAIL ready_vs_valid: in_ready=%b vec_valid=%b", in_ready, vec_valid);
      end
      if (vec_valid && !prev_vv) begin
        if (exp_q.size() < N) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got vector, queued expected=%0d need %0d", exp_q.size(), N);
        end else begin
          for (int i = 0; i < N; i++) begin
            logic signed [15:0] e;
            e = exp_q.pop_front();
            checks++;
            if (vec_out[i] !== e) begin
              errors++;
              $display("FAIL vec_out[%0d]: got %0d expected %0d", i, vec_out[i], e);
            end
          end
        end
        for (int i = 0; i < N; i++) snap[i] = vec_out[i];
      end else if (vec_valid && prev_vv) begin
        int bad;
        bad = -1;
        for (int i = 0; i < N; i++) if (vec_out[i] !== snap[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
          errors++;
          $display("FAIL hold_stable[%0d]: got %0d expected %0d", bad, vec_out[bad], snap[bad]);
        end
      end
    end
    prev_vv = vec_valid;
  end

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, want);
    end
  endtask

  task automatic check_all_zero(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < N; i++) if (vec_out[i] !== 16'sd0 && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: vec_out[%0d] got %0d expected 0", name, bad, vec_out[bad]);
    end
  endtask

  // One frame: bubbles randomize in_valid (and vec_ack, ignored while loading);
  // hold is the FULL duration with in_valid pushing new data; abort_at >= 0 resets mid-frame.
  task automatic run_frame(input int kind, input bit bubble, input int hold, input int abort_at);
    int img [H][W];
    int acc;
    int budget;
    bit v;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        case (kind)
          K_RAMP:  img[r][c] = r * 16 + c;
          K_PEAK:  img[r][c] = (r == 3 && c == 5) ? 100 : 0;
          K_NEG:   img[r][c] = -5;
          default: img[r][c] = int'($signed(16'($urandom)));
        endcase
      end
    end
    acc = 0;
    budget = 0;
    while (acc < H * W && budget < 5000) begin
      @(negedge clk);
      budget++;
      if (abort_at >= 0 && acc == abort_at) begin
        rst      = 1'b0;
        in_valid = 1'b1;
        vec_ack  = 1'b1;
        in_data  = 16'sd77;
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        vec_ack  = 1'b0;
        check_bit("reset_vec_valid", vec_valid, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_all_zero("reset_vec_out");
        return;
      end
      v = bubble ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = 16'(img[acc / W][acc % W]);
      vec_ack  = bubble ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && in_ready) begin
        acc++;
        if (acc == H * W) push_expected(img);
      end
    end
    if (acc < H * W) begin
      checks++;
      errors++;
      $display("FAIL frame_timeout: accepted %0d expected %0d", acc, H * W);
      return;
    end
    @(negedge clk);
    vec_ack = 1'b0;
    in_valid = 1'b0;
    check_bit("latency_vec_valid", vec_valid, 1'b1);
    check_bit("latency_in_ready", in_ready, 1'b0);
    for (int j = 0; j < hold; j++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      @(negedge clk);
      check_bit("full_in_ready", in_ready, 1'b0);
      check_bit("full_vec_valid", vec_valid, 1'b1);
    end
    in_valid = 1'b0;
    vec_ack  = 1'b1;
    @(negedge clk);
    vec_ack = 1'b0;
    check_bit("ack_vec_valid", vec_valid, 1'b0);
    check_bit("ack_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    vec_ack  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_bit("rst_vec_valid", vec_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_all_zero("rst_vec_out");
    mon_en = 1'b1;

    run_frame(K_RAMP, 1'b0, 0, -1);
    run_frame(K_PEAK, 1'b0, 2, -1);
    run_frame(K_NEG,  1'b0, 1, -1);
    run_frame(K_RAMP, 1'b0, 20, -1);
    run_frame(K_RAMP, 1'b0, 0, -1);
    run_frame(K_RAMP, 1'b1, 3, -1);
    run_frame(K_RAND, 1'b1, 0, -1);
    run_frame(K_RAND, 1'b0, 5, -1);
    run_frame(K_RAMP, 1'b0, 0, 100);
    run_frame(K_RAMP, 1'b0, 1, -1);

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected values left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
